// File: rtl/video_timing_drvr.sv
// video_timing_drvr: programmable H/V raster timing generator feeding pixels from a show-ahead FIFO
module video_timing_drvr #(
  parameter int PXL_W = 24,
  parameter int CNTR_W = 12,
  parameter int HS_ACTIVE_HIGH = 0,
  parameter int VS_ACTIVE_HIGH = 0,
  parameter logic [PXL_W-1:0] UFLOW_PXL = '0,
  parameter int DEF_HVALID = 1280,
  parameter int DEF_HFP = 110,
  parameter int DEF_HSYNC = 40,
  parameter int DEF_HBP = 220,
  parameter int DEF_VVALID = 720,
  parameter int DEF_VFP = 5,
  parameter int DEF_VSYNC = 5,
  parameter int DEF_VBP = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              drvr_en,
  input  logic [CNTR_W-1:0] cfg_hvalid,
  input  logic [CNTR_W-1:0] cfg_hfp,
  input  logic [CNTR_W-1:0] cfg_hsync,
  input  logic [CNTR_W-1:0] cfg_hbp,
  input  logic [CNTR_W-1:0] cfg_vvalid,
  input  logic [CNTR_W-1:0] cfg_vfp,
  input  logic [CNTR_W-1:0] cfg_vsync,
  input  logic [CNTR_W-1:0] cfg_vbp,
  input  logic              cfg_load,
  input  logic              ff_empty,
  input  logic [PXL_W-1:0]  ff_rdata,
  output logic              ff_rd_en,
  output logic [PXL_W-1:0]  vid_d,
  output logic              vid_de,
  output logic              vid_hs,
  output logic              vid_vs,
  output logic              sof,
  output logic              uflow,
  input  logic              uflow_clr,
  output logic              cfg_busy
);
  localparam int AW = CNTR_W + 2;
  localparam logic HS_ON = HS_ACTIVE_HIGH != 0;
  localparam logic VS_ON = VS_ACTIVE_HIGH != 0;
  localparam logic [7:0][CNTR_W-1:0] SH_RST = {
    CNTR_W'(DEF_VBP), CNTR_W'(DEF_VSYNC), CNTR_W'(DEF_VFP), CNTR_W'(DEF_VVALID),
    CNTR_W'(DEF_HBP), CNTR_W'(DEF_HSYNC), CNTR_W'(DEF_HFP), CNTR_W'(DEF_HVALID)};

  typedef enum logic [2:0] {IDLE, FP, SYNC, BP, VALID} st_t;

  // A zero-width region would break the state sequence, so it is widened to one count
  function automatic logic [AW-1:0] nz(input logic [CNTR_W-1:0] x);
    return (x == '0) ? AW'(1) : AW'(x);
  endfunction

  // Last count of FP, SYNC, BP and VALID (index 0..3) along one axis
  function automatic logic [3:0][AW-1:0] ends(input logic [CNTR_W-1:0] fp, sy, bp, va);
    logic [AW-1:0] a, b, c;
    a = nz(fp);
    b = a + nz(sy);
    c = b + nz(bp);
    return {c + nz(va) - AW'(1), c - AW'(1), b - AW'(1), a - AW'(1)};
  endfunction

  function automatic st_t nxt(input st_t s, input logic [AW-1:0] c, input logic [3:0][AW-1:0] b);
    case (s)
      FP:      return (c == b[0]) ? SYNC : FP;
      SYNC:    return (c == b[1]) ? BP : SYNC;
      BP:      return (c == b[2]) ? VALID : BP;
      VALID:   return (c == b[3]) ? FP : VALID;
      default: return FP;
    endcase
  endfunction

  st_t h_q, h_d, v_q, v_d;
  logic [AW-1:0] hc_q, hc_d, vc_q, vc_d;
  logic [7:0][CNTR_W-1:0] sh_q, sh_d;
  logic [3:0][AW-1:0] hb, vb;
  logic pend_q, pend_d, idle, hwrap, vlast, load, active;
  logic [PXL_W-1:0] vid_d_q, vid_d_d;
  logic vid_de_q, vid_de_d, vid_hs_q, vid_hs_d, vid_vs_q, vid_vs_d;
  logic sof_q, sof_d, uflow_q, uflow_d;

  assign hb = ends(sh_q[1], sh_q[2], sh_q[3], sh_q[0]);
  assign vb = ends(sh_q[5], sh_q[6], sh_q[7], sh_q[4]);

  // Raster FSMs and counters; shadow swaps only at a frame edge or while idle
  always_comb begin
    idle = h_q == IDLE;
    hwrap = hc_q == hb[3];
    vlast = vc_q == vb[3];
    load = pend_q & (idle | (hwrap & vlast));
    h_d = !drvr_en ? IDLE : idle ? FP : nxt(h_q, hc_q, hb);
    v_d = !drvr_en ? IDLE : idle ? FP : hwrap ? nxt(v_q, vc_q, vb) : v_q;
    hc_d = (!drvr_en || idle || hwrap) ? '0 : hc_q + AW'(1);
    vc_d = (!drvr_en || idle || (hwrap && vlast)) ? '0 : hwrap ? vc_q + AW'(1) : vc_q;
    sh_d = load ? {cfg_vbp, cfg_vsync, cfg_vfp, cfg_vvalid, cfg_hbp, cfg_hsync, cfg_hfp, cfg_hvalid} : sh_q;
    pend_d = cfg_load | (pend_q & ~load);
  end

  // Video outputs are computed from the current state and registered one cycle later
  always_comb begin
    active = (h_q == VALID) && (v_q == VALID);
    ff_rd_en = active & ~ff_empty;
    vid_de_d = active;
    vid_hs_d = (h_q == SYNC) ? HS_ON : ~HS_ON;
    vid_vs_d = (v_q == SYNC) ? VS_ON : ~VS_ON;
    vid_d_d = !active ? '0 : ff_empty ? UFLOW_PXL : ff_rdata;
    uflow_d = (active & ff_empty) | (uflow_q & ~uflow_clr);
    sof_d = (hc_q == '0) && (vc_q == '0) && (v_q == FP);
  end

  // Timing state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q <= IDLE;
      v_q <= IDLE;
      hc_q <= '0;
      vc_q <= '0;
      sh_q <= SH_RST;
      pend_q <= 1'b0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
      hc_q <= hc_d;
      vc_q <= vc_d;
      sh_q <= sh_d;
      pend_q <= pend_d;
    end
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vid_d_q <= '0;
      vid_de_q <= 1'b0;
      vid_hs_q <= ~HS_ON;
      vid_vs_q <= ~VS_ON;
      sof_q <= 1'b0;
      uflow_q <= 1'b0;
    end else begin
      vid_d_q <= vid_d_d;
      vid_de_q <= vid_de_d;
      vid_hs_q <= vid_hs_d;
      vid_vs_q <= vid_vs_d;
      sof_q <= sof_d;
      uflow_q <= uflow_d;
    end
  end

  assign vid_d = vid_d_q;
  assign vid_de = vid_de_q;
  assign vid_hs = vid_hs_q;
  assign vid_vs = vid_vs_q;
  assign sof = sof_q;
  assign uflow = uflow_q;
  assign cfg_busy = pend_q;
endmodule

// File: tb/tb_video_timing_drvr.sv
// tb_video_timing_drvr: table, directed and random checks of video_timing_drvr against a frame-position model
module tb_video_timing_drvr;
  localparam int PW = 8;
  localparam int CW = 6;
  localparam logic [PW-1:0] UF = 8'hA5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic drvr_en = 1'b0;
  logic cfg_load = 1'b0;
  logic ff_empty = 1'b1;
  logic uflow_clr = 1'b0;
  logic [CW-1:0] cfg_hvalid = 4, cfg_hfp = 1, cfg_hsync = 2, cfg_hbp = 1;
  logic [CW-1:0] cfg_vvalid = 2, cfg_vfp = 1, cfg_vsync = 1, cfg_vbp = 1;
  logic [PW-1:0] ff_rdata = '0;
  logic ff_rd_en, vid_de, vid_hs, vid_vs, sof, uflow, cfg_busy;
  logic [PW-1:0] vid_d;

  always #5 clk = ~clk;

  video_timing_drvr #(
    .PXL_W(PW), .CNTR_W(CW), .HS_ACTIVE_HIGH(0), .VS_ACTIVE_HIGH(0), .UFLOW_PXL(UF),
    .DEF_HVALID(4), .DEF_HFP(1), .DEF_HSYNC(2), .DEF_HBP(1),
    .DEF_VVALID(2), .DEF_VFP(1), .DEF_VSYNC(1), .DEF_VBP(1)
  ) dut (
    .clk(clk), .rst(rst), .drvr_en(drvr_en),
    .cfg_hvalid(cfg_hvalid), .cfg_hfp(cfg_hfp), .cfg_hsync(cfg_hsync), .cfg_hbp(cfg_hbp),
    .cfg_vvalid(cfg_vvalid), .cfg_vfp(cfg_vfp), .cfg_vsync(cfg_vsync), .cfg_vbp(cfg_vbp),
    .cfg_load(cfg_load), .ff_empty(ff_empty), .ff_rdata(ff_rdata), .ff_rd_en(ff_rd_en),
    .vid_d(vid_d), .vid_de(vid_de), .vid_hs(vid_hs), .vid_vs(vid_vs), .sof(sof),
    .uflow(uflow), .uflow_clr(uflow_clr), .cfg_busy(cfg_busy)
  );

  int checks = 0;
  int errors = 0;

  // Model: a running flag, a linear pixel position within the frame and the shadow widths
  // ordered hvalid, hfp, hsync, hbp, vvalid, vfp, vsync, vbp
  int m_run, m_p, m_pend, m_uf;
  int sh[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int region(input int x, input int fp, input int sy, input int bp);
    return x < fp ? 0 : x < fp + sy ? 1 : x < fp + sy + bp ? 2 : 3;
  endfunction

  function automatic int ht();
    return sh[0] + sh[1] + sh[2] + sh[3];
  endfunction

  function automatic int vt();
    return sh[4] + sh[5] + sh[6] + sh[7];
  endfunction

  function automatic bit m_active();
    return m_run != 0 && region(m_p % ht(), sh[1], sh[2], sh[3]) == 3 &&
           region(m_p / ht(), sh[5], sh[6], sh[7]) == 3;
  endfunction

  function automatic int nzi(input logic [CW-1:0] x);
    return x == '0 ? 1 : int'(x);
  endfunction

  task automatic model_reset();
    m_run = 0;
    m_p = 0;
    m_pend = 0;
    m_uf = 0;
    sh = '{4, 1, 2, 1, 2, 1, 1, 1};
  endtask

  // One clock: inputs are sampled at the falling edge, registered outputs checked 1 after the rising edge
  task automatic step();
    int t, hr, vr, np, npend;
    int nsh[8];
    bit act, last, load, en, ehs, evs, esof, euf;
    logic [PW-1:0] ed;
    @(negedge clk);
    t = ht();
    hr = region(m_p % t, sh[1], sh[2], sh[3]);
    vr = region(m_p / t, sh[5], sh[6], sh[7]);
    act = m_active();
    chk("ff_rd_en", 32'(ff_rd_en), 32'(act && !ff_empty));
    ehs = !(m_run != 0 && hr == 1);
    evs = !(m_run != 0 && vr == 1);
    esof = m_run != 0 && m_p == 0;
    ed = !act ? '0 : ff_empty ? UF : ff_rdata;
    euf = (act && ff_empty) || (m_uf != 0 && !uflow_clr);
    last = m_run != 0 && m_p == t * vt() - 1;
    load = m_pend != 0 && (m_run == 0 || last);
    en = drvr_en;
    np = (!en || m_run == 0 || last) ? 0 : m_p + 1;
    npend = (cfg_load || (m_pend != 0 && !load)) ? 1 : 0;
    nsh = '{nzi(cfg_hvalid), nzi(cfg_hfp), nzi(cfg_hsync), nzi(cfg_hbp),
            nzi(cfg_vvalid), nzi(cfg_vfp), nzi(cfg_vsync), nzi(cfg_vbp)};
    @(posedge clk);
    #1;
    chk("vid_de", 32'(vid_de), 32'(act));
    chk("vid_hs", 32'(vid_hs), 32'(ehs));
    chk("vid_vs", 32'(vid_vs), 32'(evs));
    chk("sof", 32'(sof), 32'(esof));
    chk("vid_d", 32'(vid_d), 32'(ed));
    chk("uflow", 32'(uflow), 32'(euf));
    chk("cfg_busy", 32'(cfg_busy), 32'(npend));
    m_p = np;
    m_run = en ? 1 : 0;
    m_pend = npend;
    m_uf = euf ? 1 : 0;
    if (load) sh = nsh;
  endtask

  // Asynchronous reset: outputs must change before any clock edge
  task automatic do_reset();
    drvr_en = 1'b0;
    cfg_load = 1'b0;
    uflow_clr = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_de", 32'(vid_de), 0);
    chk("rst_hs", 32'(vid_hs), 1);
    chk("rst_vs", 32'(vid_vs), 1);
    chk("rst_sof", 32'(sof), 0);
    chk("rst_uflow", 32'(uflow), 0);
    chk("rst_busy", 32'(cfg_busy), 0);
    chk("rst_vid_d", 32'(vid_d), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  task automatic adv_active();
    for (int i = 0; i < 300 && !m_active(); i++) step();
    if (!m_active()) chk("reach_active", 0, 1);
  endtask

  task automatic wait_sof(output int n);
    n = 0;
    for (int i = 1; i <= 500; i++) begin
      step();
      n = i;
      if (sof) break;
    end
    if (!sof) chk("sof_timeout", 0, 1);
  endtask

  typedef struct {
    int s;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl[16];
  logic [3:0] obs[83];

  initial begin
    int n, cde, chs, cvs, csf;
    // {de, hs, vs, sof} at step s; step s shows frame position s-2 (8 px/line, 5 lines)
    tbl[0]  = '{2,  4'b0111};
    tbl[1]  = '{3,  4'b0010};
    tbl[2]  = '{4,  4'b0010};
    tbl[3]  = '{5,  4'b0110};
    tbl[4]  = '{10, 4'b0100};
    tbl[5]  = '{11, 4'b0000};
    tbl[6]  = '{18, 4'b0110};
    tbl[7]  = '{29, 4'b0110};
    tbl[8]  = '{30, 4'b1110};
    tbl[9]  = '{33, 4'b1110};
    tbl[10] = '{34, 4'b0110};
    tbl[11] = '{38, 4'b1110};
    tbl[12] = '{42, 4'b0111};
    tbl[13] = '{43, 4'b0010};
    tbl[14] = '{82, 4'b0111};
    tbl[15] = '{1,  4'b0110};
    #3;
    do_reset();

    drvr_en = 1'b1;
    ff_empty = 1'b0;
    for (int s = 1; s <= 82; s++) begin
      ff_rdata = PW'($urandom);
      step();
      obs[s] = {vid_de, vid_hs, vid_vs, sof};
    end
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("tbl_de_s%0d", tbl[i].s), 32'(obs[tbl[i].s][3]), 32'(tbl[i].exp[3]));
      chk($sformatf("tbl_hs_s%0d", tbl[i].s), 32'(obs[tbl[i].s][2]), 32'(tbl[i].exp[2]));
      chk($sformatf("tbl_vs_s%0d", tbl[i].s), 32'(obs[tbl[i].s][1]), 32'(tbl[i].exp[1]));
      chk($sformatf("tbl_sof_s%0d", tbl[i].s), 32'(obs[tbl[i].s][0]), 32'(tbl[i].exp[0]));
    end
    cde = 0; chs = 0; cvs = 0; csf = 0;
    for (int s = 2; s <= 41; s++) begin
      cde += int'(obs[s][3]);
      chs += int'(!obs[s][2]);
      cvs += int'(!obs[s][1]);
      csf += int'(obs[s][0]);
    end
    chk("frame_de_count", cde, 8);
    chk("frame_hs_low_count", chs, 10);
    chk("frame_vs_low_count", cvs, 8);
    chk("frame_sof_count", csf, 1);

    adv_active();
    ff_empty = 1'b1;
    step();
    chk("uflow_set", 32'(uflow), 1);
    chk("uflow_pxl", 32'(vid_d), 32'(UF));
    ff_empty = 1'b0;
    repeat (3) step();
    chk("uflow_sticky", 32'(uflow), 1);
    adv_active();
    ff_empty = 1'b1;
    uflow_clr = 1'b1;
    step();
    chk("uflow_set_beats_clr", 32'(uflow), 1);
    ff_empty = 1'b0;
    step();
    chk("uflow_clr", 32'(uflow), 0);
    uflow_clr = 1'b0;

    repeat (5) step();
    cfg_hvalid = 8;
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    chk("cfg_busy_set", 32'(cfg_busy), 1);
    wait_sof(n);
    chk("cfg_busy_cleared", 32'(cfg_busy), 0);
    wait_sof(n);
    chk("period_htotal12", n, 60);

    adv_active();
    drvr_en = 1'b0;
    step();
    step();
    chk("dis_de", 32'(vid_de), 0);
    chk("dis_hs", 32'(vid_hs), 1);
    chk("dis_vs", 32'(vid_vs), 1);
    drvr_en = 1'b1;
    step();
    chk("reen_sof_early", 32'(sof), 0);
    step();
    chk("reen_sof", 32'(sof), 1);

    adv_active();
    step();
    chk("de_before_rst", 32'(vid_de), 1);
    #2;
    do_reset();
    drvr_en = 1'b1;
    wait_sof(n);
    wait_sof(n);
    chk("period_after_rst", n, 40);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) == 0) do_reset();
      if ($urandom_range(0, 49) == 0) begin
        cfg_hvalid = CW'($urandom_range(0, 4)); cfg_hfp = CW'($urandom_range(0, 3));
        cfg_hsync = CW'($urandom_range(0, 3));  cfg_hbp = CW'($urandom_range(0, 3));
        cfg_vvalid = CW'($urandom_range(0, 4)); cfg_vfp = CW'($urandom_range(0, 3));
        cfg_vsync = CW'($urandom_range(0, 3));  cfg_vbp = CW'($urandom_range(0, 3));
      end
      drvr_en = $urandom_range(0, 63) != 0;
      ff_empty = $urandom_range(0, 7) == 0;
      ff_rdata = PW'($urandom);
      uflow_clr = $urandom_range(0, 15) == 0;
      cfg_load = $urandom_range(0, 99) == 0;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/video_timing_drvr.md
VIDEO_TIMING_DRVR -- requirements
Module: video_timing_drvr

Interface
REQ-001 Parameter PXL_W, default 24, width of pixel data in bits.
REQ-002 Parameter CNTR_W, default 12, width of the H/V counters and timing config fields.
REQ-003 Parameter HS_ACTIVE_HIGH, default 0, HSYNC active level (1 = high).
REQ-004 Parameter VS_ACTIVE_HIGH, default 0, VSYNC active level (1 = high).
REQ-005 Parameter UFLOW_PXL, default 0, pixel value driven when the FIFO is empty during active video.
REQ-006 Parameters DEF_HVALID/HFP/HSYNC/HBP, default 1280/110/40/220, reset values of the H config shadow.
REQ-007 Parameters DEF_VVALID/VFP/VSYNC/VBP, default 720/5/5/20, reset values of the V config shadow.
REQ-008 clk  in  1  single clock; all logic rising-edge.
REQ-009 rst  in  1  asynchronous, active-high reset.
REQ-010 drvr_en  in  1  timing generation enable.
REQ-011 cfg_hvalid, cfg_hfp, cfg_hsync, cfg_hbp  in  CNTR_W each  requested H region widths.
REQ-012 cfg_vvalid, cfg_vfp, cfg_vsync, cfg_vbp  in  CNTR_W each  requested V region widths in lines.
REQ-013 cfg_load  in  1  pulse; requests a config update at the next frame boundary.
REQ-014 ff_empty  in  1  pixel FIFO empty; ff_rdata  in  PXL_W  FIFO read data (show-ahead).
REQ-015 ff_rd_en  out  1  FIFO pop, combinational.
REQ-016 vid_d  out  PXL_W; vid_de, vid_hs, vid_vs  out  1 each  registered video outputs.
REQ-017 sof  out  1  registered one-cycle start-of-frame pulse.
REQ-018 uflow  out  1  sticky underflow flag; uflow_clr  in  1  clears it.
REQ-019 cfg_busy  out  1  high while a cfg_load is pending.

Function
REQ-020 Line order SHALL be FP, SYNC, BP, VALID; hcntr runs 0..HTOTAL-1, HTOTAL = hfp+hsync+hbp+hvalid from the active shadow.
REQ-021 Frame order SHALL be FP, SYNC, BP, VALID lines; vcntr runs 0..VTOTAL-1 and increments only on hcntr wrap.
REQ-022 Each H and V FSM SHALL have states IDLE, FP, SYNC, BP, VALID, advancing when the counter hits the last count of the current region.
REQ-023 drvr_en low SHALL force both FSMs to IDLE and both counters to 0 on the next edge; from IDLE with drvr_en high, both SHALL enter FP at count 0.
REQ-024 Counter and boundary arithmetic SHALL be CNTR_W+2 bits wide so sums never overflow.
REQ-025 Any config field of 0 SHALL be treated as 1.
REQ-026 Active shadow SHALL load from the cfg_* inputs when cfg_load is pending and (vcntr wrap occurs or FSMs are IDLE); cfg_busy SHALL be high from the cycle after cfg_load until the load cycle.
REQ-027 A cfg_load arriving on the load cycle itself SHALL stay pending for the following frame.
REQ-028 Active window = H VALID and V VALID; ff_rd_en = active & ~ff_empty.
REQ-029 Outputs SHALL lag FSM state by exactly 1 cycle: vid_de = active; vid_hs/vid_vs = active level in the respective SYNC state, else inactive.
REQ-030 vid_d SHALL be ff_rdata when active and FIFO non-empty, UFLOW_PXL when active and empty, 0 otherwise.
REQ-031 uflow SHALL set on any active cycle with ff_empty high; uflow_clr SHALL clear it, with set winning if both occur in the same cycle.
REQ-032 sof SHALL pulse for one cycle when hcntr=0 and vcntr=0 and V FSM is in FP (registered, aligned with the other outputs).

Reset
REQ-033 On rst: FSMs IDLE, counters 0, shadow = DEF_* values, pending load cleared, vid_d=0, vid_de=0, sof=0, uflow=0, cfg_busy=0, vid_hs/vid_vs at inactive level.
REQ-034 rst asserted mid-frame SHALL take effect immediately (asynchronously) on all registered outputs.

Verification
REQ-035 Shadow H=4/1/2/1, V=2/1/1/1, drvr_en=1, FIFO never empty -> HTOTAL 8, frame 40 cycles, vid_de high 4 cycles per line on 2 lines, sof period 40.
REQ-036 Same config, HS_ACTIVE_HIGH=0 -> vid_hs low for exactly 2 cycles per line, at output cycles 2-3 after line start; vid_vs low for exactly 1 line (8 cycles).
REQ-037 ff_empty high for one active pixel -> vid_d=UFLOW_PXL that cycle, ff_rd_en=0, uflow=1 until uflow_clr; uflow_clr coincident with a new underflow -> uflow stays 1.
REQ-038 cfg_load mid-frame with hvalid=8 -> cfg_busy high until frame end; next frame has HTOTAL 12, current frame unchanged.
REQ-039 drvr_en deasserted mid-line -> next cycle FSMs IDLE, following cycle vid_de=0 and syncs inactive; re-enable -> sof 1 cycle after entering FP.
REQ-040 rst pulsed mid-active-video -> all outputs at reset values immediately, shadow reverts to DEF_* timing.
